detector_jogada: RTL and testbench

Input stage directly upstream of the game control unit. Filters the raw player buttons and turns each clean, single-button press into a one-cycle `jogada` pulse with a held one-hot `valor`. `valor` feeds the play register; `jogada` feeds the control unit. Presses count only while the control unit asserts `pode_jogar`; each physical press yields at most one `jogada`.

---
 rtl/detector_jogada.sv | 120 ++++++++++++
 tb/tb_detector_jogada.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - debounced single-button press detector; optional input synchroniser via DETECTOR_JOGADA_SYNC_EN
module detector_jogada #(
  parameter int NBOT            = 4,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pode_jogar,
  input  logic [NBOT-1:0] botoes,
  output logic            jogada,
  output logic [NBOT-1:0] valor,
  output logic            erro_multiplo,
  output logic            ocupado,
  output logic [3:0]      db_estado
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [3:0] {
    ESPERA = 4'd0,
    FILTRA = 4'd1,
    PULSO  = 4'd2,
    SOLTA  = 4'd3
  } estado_t;

  estado_t         estado_q;
  logic [NBOT-1:0] amostra_q;
  logic [CW-1:0]   contador_q;
  logic [NBOT-1:0] valor_q;
  logic            jogada_q;
  logic            erro_q;
  logic [NBOT-1:0] b;

`ifdef DETECTOR_JOGADA_SYNC_EN
  logic [NBOT-1:0] b_meta_q;
  logic [NBOT-1:0] b_sync_q;

  // Two-flop synchroniser for the asynchronous button levels
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b_meta_q <= '0;
      b_sync_q <= '0;
    end else begin
      b_meta_q <= botoes;
      b_sync_q <= b_meta_q;
    end
  end

  assign b = b_sync_q;
`else
  assign b = botoes;
`endif

  // Press filter FSM: sample, hold-stable count, pulse once, then wait for a clean release
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= ESPERA;
      amostra_q  <= '0;
      contador_q <= '0;
      valor_q    <= '0;
      jogada_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      jogada_q <= 1'b0;
      erro_q   <= 1'b0;
      case (estado_q)
        ESPERA: begin
          if (pode_jogar && (b != '0)) begin
            estado_q   <= FILTRA;
            amostra_q  <= b;
            contador_q <= '0;
          end
        end
        FILTRA: begin
          if (!pode_jogar || (b != amostra_q)) begin
            estado_q <= ESPERA;
          end else if (contador_q == CNT_MAX) begin
            if ($onehot(amostra_q)) begin
              estado_q <= PULSO;
            end else begin
              // Chord of buttons: flag it and go straight to waiting for release
              estado_q   <= SOLTA;
              erro_q     <= 1'b1;
              contador_q <= '0;
            end
          end else begin
            contador_q <= contador_q + 1'b1;
          end
        end
        PULSO: begin
          // Committed: pode_jogar is not re-checked here
          jogada_q   <= 1'b1;
          valor_q    <= amostra_q;
          estado_q   <= SOLTA;
          contador_q <= '0;
        end
        SOLTA: begin
          if (b != '0) begin
            contador_q <= '0;
          end else if (contador_q == CNT_MAX) begin
            estado_q <= ESPERA;
          end else begin
            contador_q <= contador_q + 1'b1;
          end
        end
        default: begin
          estado_q <= ESPERA;
        end
      endcase
    end
  end

  assign jogada        = jogada_q;
  assign erro_multiplo = erro_q;
  assign valor         = valor_q;
  assign ocupado       = (estado_q != ESPERA);
  assign db_estado     = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// tb/tb_detector_jogada.sv - directed self-checking bench for detector_jogada
module tb_detector_jogada;

`ifdef DETECTOR_JOGADA_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic       clock;
  logic       reset;
  logic       pode_jogar;
  logic [3:0] botoes;
  logic       jogada;
  logic [3:0] valor;
  logic       erro_multiplo;
  logic       ocupado;
  logic [3:0] db_estado;

  int total;
  int passed;
  int tick;
  int jog_count;
  int first_jog;
  int err_count;
  int ocu_count;
  int both_count;

  detector_jogada #(
    .NBOT            (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pode_jogar    (pode_jogar),
    .botoes        (botoes),
    .jogada        (jogada),
    .valor         (valor),
    .erro_multiplo (erro_multiplo),
    .ocupado       (ocupado),
    .db_estado     (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear();
    tick       = 0;
    jog_count  = 0;
    first_jog  = -1;
    err_count  = 0;
    ocu_count  = 0;
  endtask

  // Advance n clock edges, sampling 1 time unit after each rising edge
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      tick++;
      if (jogada) begin
        jog_count++;
        if (first_jog < 0) first_jog = tick;
      end
      if (erro_multiplo) err_count++;
      if (ocupado) ocu_count++;
      if (jogada && erro_multiplo) both_count++;
    end
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    both_count = 0;
    clear();
    reset      = 1'b1;
    pode_jogar = 1'b0;
    botoes     = 4'b0000;
    run(3);
    reset = 1'b0;
    run(2);
    check("rst_jogada", int'(jogada), 0);
    check("rst_valor", int'(valor), 0);
    check("rst_erro", int'(erro_multiplo), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_estado", int'(db_estado), 0);

    // Single press held 20 cycles, then released
    clear();
    pode_jogar = 1'b1;
    botoes     = 4'b0010;
    run(20);
    check("s1_jog_count", jog_count, 1);
    check("s1_jog_tick", first_jog, 6 + S);
    check("s1_valor", int'(valor), 4'b0010);
    botoes = 4'b0000;
    run(3 + S);
    check("s1_still_solta", int'(db_estado), 3);
    run(1);
    check("s1_back_espera", int'(db_estado), 0);
    run(6 - S);

    // Short bounce then stable press
    clear();
    botoes = 4'b0001;
    run(2);
    botoes = 4'b0000;
    run(1);
    botoes = 4'b0001;
    run(12);
    check("s2_jog_count", jog_count, 1);
    check("s2_jog_tick", first_jog, 9 + S);
    check("s2_valor", int'(valor), 4'b0001);
    botoes = 4'b0000;
    run(8 + S);
    check("s2_release", int'(db_estado), 0);

    // Two buttons at once
    clear();
    botoes = 4'b0101;
    run(10);
    check("s3_erro_count", err_count, 1);
    check("s3_jog_count", jog_count, 0);
    check("s3_valor_kept", int'(valor), 4'b0001);
    check("s3_solta", int'(db_estado), 3);
    botoes = 4'b0000;
    run(8 + S);
    check("s3_release", int'(db_estado), 0);

    // Button held while presses are not allowed, then allowed
    clear();
    pode_jogar = 1'b0;
    botoes     = 4'b1000;
    run(6);
    check("s4_idle_ocupado", ocu_count, 0);
    check("s4_idle_jog", jog_count, 0);
    clear();
    pode_jogar = 1'b1;
    run(10);
    check("s4_jog_tick", first_jog, 6);
    check("s4_valor", int'(valor), 4'b1000);
    botoes = 4'b0000;
    run(8 + S);

    // Reset in the middle of the filter
    clear();
    botoes = 4'b0100;
    run(3 + S);
    check("s5_in_filtra", int'(db_estado), 1);
    reset = 1'b1;
    #1;
    check("s5_rst_jogada", int'(jogada), 0);
    check("s5_rst_valor", int'(valor), 0);
    check("s5_rst_ocupado", int'(ocupado), 0);
    check("s5_rst_estado", int'(db_estado), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear();
    run(12);
    check("s5_jog_tick", first_jog, 6 + S);
    check("s5_jog_count", jog_count, 1);
    check("s5_valor", int'(valor), 4'b0100);

    check("never_both", both_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
